fetch_unit: RTL and testbench

Instruction fetch stage that drives the instruction register feeding the opcode decoder. Holds the PC and issues word reads to instruction memory over a req/ready handshake. Presents `ir` / `opcode` with a valid flag, holds it under decode stall, and flushes/redirects on taken branches (JF) and jumps (LOADBR). Stops fetching after a HALT instruction.

---
 rtl/fetch_unit_pkg.sv | 40 ++++
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit_pc_counter.sv | 25 ++
 rtl/fetch_unit.sv | 70 +++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: widths, opcode field position, opcode set and FSM states.
package fetch_unit_pkg;

   localparam int unsigned ADDR_W     = 16;
   localparam int unsigned INSTR_W    = 16;
   localparam int unsigned OPCODE_W   = 5;
   localparam int unsigned OPCODE_MSB = INSTR_W - 1;
   localparam int unsigned OPCODE_LSB = INSTR_W - OPCODE_W;

   // Full opcode set, shared with the decoder
   localparam logic [OPCODE_W-1:0] OP_NOP    = 5'd0;
   localparam logic [OPCODE_W-1:0] OP_ADD    = 5'd1;
   localparam logic [OPCODE_W-1:0] OP_SUB    = 5'd2;
   localparam logic [OPCODE_W-1:0] OP_MOV    = 5'd3;
   localparam logic [OPCODE_W-1:0] OP_INC    = 5'd4;
   localparam logic [OPCODE_W-1:0] OP_DEC    = 5'd5;
   localparam logic [OPCODE_W-1:0] OP_AND    = 5'd6;
   localparam logic [OPCODE_W-1:0] OP_OR     = 5'd7;
   localparam logic [OPCODE_W-1:0] OP_XOR    = 5'd8;
   localparam logic [OPCODE_W-1:0] OP_NOT    = 5'd9;
   localparam logic [OPCODE_W-1:0] OP_SHL    = 5'd10;
   localparam logic [OPCODE_W-1:0] OP_SHR    = 5'd11;
   localparam logic [OPCODE_W-1:0] OP_LOAD   = 5'd12;
   localparam logic [OPCODE_W-1:0] OP_STORE  = 5'd13;
   localparam logic [OPCODE_W-1:0] OP_LOADI  = 5'd14;
   localparam logic [OPCODE_W-1:0] OP_CMP    = 5'd15;
   localparam logic [OPCODE_W-1:0] OP_JF     = 5'd16;
   localparam logic [OPCODE_W-1:0] OP_LOADBR = 5'd17;
   localparam logic [OPCODE_W-1:0] OP_HALT   = 5'd31;

   typedef enum logic {
      S_FETCH  = 1'b0,
      S_HALTED = 1'b1
   } fetch_state_e;

   function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] word);
      return word[OPCODE_MSB -: OPCODE_W];
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake, redirect input and the IR presented to decode.
interface fetch_unit_if;

   logic                                   imem_req;
   logic [fetch_unit_pkg::ADDR_W-1:0]      imem_addr;
   logic                                   imem_ready;
   logic [fetch_unit_pkg::INSTR_W-1:0]     imem_rdata;
   logic                                   stall;
   logic                                   redirect_valid;
   logic [fetch_unit_pkg::ADDR_W-1:0]      redirect_pc;
   logic [fetch_unit_pkg::INSTR_W-1:0]     ir;
   logic                                   ir_valid;
   logic [fetch_unit_pkg::OPCODE_W-1:0]    opcode;
   logic [fetch_unit_pkg::ADDR_W-1:0]      ir_pc;
   logic                                   halted;

   modport master (
      output imem_req, imem_addr, ir, ir_valid, opcode, ir_pc, halted,
      input  imem_ready, imem_rdata, stall, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, ir, ir_valid, opcode, ir_pc, halted,
      output imem_ready, imem_rdata, stall, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: sync reset to RESET_PC, redirect load beats increment, wraps mod 2^ADDR_W.
module pc_counter
   import fetch_unit_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_pc,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_pc;
      end else if (inc) begin
         pc <= pc + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem handshake, instruction register with stall hold,
// redirect flush and HALT stop.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);

   fetch_state_e         state;
   logic [INSTR_W-1:0]   ir;
   logic                 ir_valid;
   logic [ADDR_W-1:0]    ir_pc;
   logic                 halted;
   logic [ADDR_W-1:0]    pc;
   logic                 req;
   logic                 accept;

   // Request only when the IR slot is free or being consumed this cycle
   assign req    = !rst && (state == S_FETCH) && (!ir_valid || !bus.stall);
   assign accept = req && bus.imem_ready && !bus.redirect_valid;

   pc_counter #(
      .RESET_PC (RESET_PC)
   ) u_pc_counter (
      .clk     (clk),
      .rst     (rst),
      .load    (bus.redirect_valid),
      .load_pc (bus.redirect_pc),
      .inc     (accept),
      .pc      (pc)
   );

   // Redirect outranks accept; a speculatively fetched HALT is undone by the redirect
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         ir       <= '0;
         ir_valid <= 1'b0;
         ir_pc    <= '0;
         halted   <= 1'b0;
      end else if (bus.redirect_valid) begin
         state    <= S_FETCH;
         ir_valid <= 1'b0;
         halted   <= 1'b0;
      end else if (accept) begin
         ir       <= bus.imem_rdata;
         ir_pc    <= pc;
         ir_valid <= 1'b1;
         if (get_opcode(bus.imem_rdata) == OP_HALT) begin
            state  <= S_HALTED;
            halted <= 1'b1;
         end
      end else if (ir_valid && !bus.stall) begin
         ir_valid <= 1'b0;
      end
   end

   assign bus.imem_req  = req;
   assign bus.imem_addr = pc;
   assign bus.ir        = ir;
   assign bus.ir_valid  = ir_valid;
   assign bus.opcode    = get_opcode(ir);
   assign bus.ir_pc     = ir_pc;
   assign bus.halted    = halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand-written HALT/reset sequences.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic clk = 1'b0;
   logic rst;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC('0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [INSTR_W-1:0] mem [0:65535];
   assign bus.imem_rdata = mem[bus.imem_addr];

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic              rst;
      logic              stall;
      logic              ready;
      logic              rv;
      logic [ADDR_W-1:0] rpc;
      logic              e_req;
      logic [ADDR_W-1:0] e_addr;
      logic              e_iv;
      logic [ADDR_W-1:0] e_irpc;
      logic              e_halt;
      logic [4:0]        e_op;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic s, input logic rdy, input logic rv,
                               input logic [ADDR_W-1:0] rpc, input logic req,
                               input logic [ADDR_W-1:0] addr, input logic iv,
                               input logic [ADDR_W-1:0] irpc, input logic hlt,
                               input logic [4:0] op);
      vec_t v;
      v.rst = r; v.stall = s; v.ready = rdy; v.rv = rv; v.rpc = rpc;
      v.e_req = req; v.e_addr = addr; v.e_iv = iv; v.e_irpc = irpc;
      v.e_halt = hlt; v.e_op = op;
      return v;
   endfunction

   function automatic logic [INSTR_W-1:0] word(input logic [4:0] op, input logic [ADDR_W-1:0] a);
      return {op, 11'(a)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic s, input logic rdy, input logic rv,
                        input logic [ADDR_W-1:0] rpc);
      rst = r; bus.stall = s; bus.imem_ready = rdy;
      bus.redirect_valid = rv; bus.redirect_pc = rpc;
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = word(OP_NOP, ADDR_W'(a));
      mem[0]      = word(OP_ADD, 16'h0000);
      mem[1]      = word(OP_SUB, 16'h0001);
      mem[2]      = word(OP_MOV, 16'h0002);
      mem[3]      = word(OP_INC, 16'h0003);
      mem[4]      = word(OP_ADD, 16'h0004);
      mem[5]      = word(OP_SUB, 16'h0005);
      mem[16'h10] = word(OP_ADD, 16'h0010);
      mem[16'h40] = word(OP_MOV, 16'h0040);
      mem[16'h41] = word(OP_INC, 16'h0041);
      mem[16'hFFFF] = word(OP_SUB, 16'hFFFF);

      // rst stall rdy rv rpc | req addr iv irpc halt op
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0000,0,16'h0000,0,OP_NOP)); // c0 first fetch
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0001,1,16'h0000,0,OP_ADD));
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0002,1,16'h0001,0,OP_SUB));
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0003,1,16'h0002,0,OP_MOV));
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0004,1,16'h0003,0,OP_INC));
      vecs.push_back(mk(0,0,1,1,16'h0040,  1,16'h0005,1,16'h0004,0,OP_ADD)); // redirect vs accept @5
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0040,0,16'h0000,0,OP_NOP));
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0041,1,16'h0040,0,OP_MOV));
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0042,1,16'h0041,0,OP_INC));
      vecs.push_back(mk(1,0,1,0,16'h0,     0,16'h0043,1,16'h0042,0,OP_NOP)); // reset
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0000,0,16'h0000,0,OP_NOP));
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0001,1,16'h0000,0,OP_ADD));
      vecs.push_back(mk(0,1,1,0,16'h0,     0,16'h0002,1,16'h0001,0,OP_SUB)); // stall x3
      vecs.push_back(mk(0,1,1,0,16'h0,     0,16'h0002,1,16'h0001,0,OP_SUB));
      vecs.push_back(mk(0,1,1,0,16'h0,     0,16'h0002,1,16'h0001,0,OP_SUB));
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0002,1,16'h0001,0,OP_SUB));
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0003,1,16'h0002,0,OP_MOV));
      vecs.push_back(mk(0,1,1,1,16'h0010,  0,16'h0004,1,16'h0003,0,OP_INC)); // redirect under stall
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0010,0,16'h0000,0,OP_NOP));
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0011,1,16'h0010,0,OP_ADD));
      vecs.push_back(mk(0,0,0,0,16'h0,     1,16'h0012,1,16'h0011,0,OP_NOP)); // wait states
      vecs.push_back(mk(0,0,0,0,16'h0,     1,16'h0012,0,16'h0000,0,OP_NOP));
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0012,0,16'h0000,0,OP_NOP));
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0013,1,16'h0012,0,OP_NOP));
      vecs.push_back(mk(0,0,0,1,16'hFFFF,  1,16'h0014,1,16'h0013,0,OP_NOP)); // wrap
      vecs.push_back(mk(0,0,0,0,16'h0,     1,16'hFFFF,0,16'h0000,0,OP_NOP));
      vecs.push_back(mk(0,0,0,0,16'h0,     1,16'hFFFF,0,16'h0000,0,OP_NOP));
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'hFFFF,0,16'h0000,0,OP_NOP));
      vecs.push_back(mk(0,0,0,0,16'h0,     1,16'h0000,1,16'hFFFF,0,OP_SUB));
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0000,0,16'h0000,0,OP_NOP));
      vecs.push_back(mk(0,0,1,0,16'h0,     1,16'h0001,1,16'h0000,0,OP_ADD));

      drive(1, 0, 1, 0, '0);
      tick();
      tick();
      chk("rst.req",      32'(bus.imem_req),  32'h0);
      chk("rst.addr",     32'(bus.imem_addr), 32'h0);
      chk("rst.ir_valid", 32'(bus.ir_valid),  32'h0);
      chk("rst.ir",       32'(bus.ir),        32'h0);
      chk("rst.ir_pc",    32'(bus.ir_pc),     32'h0);
      chk("rst.halted",   32'(bus.halted),    32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].stall, vecs[i].ready, vecs[i].rv, vecs[i].rpc);
         #1;
         chk($sformatf("v%0d.req", i),      32'(bus.imem_req),  32'(vecs[i].e_req));
         chk($sformatf("v%0d.addr", i),     32'(bus.imem_addr), 32'(vecs[i].e_addr));
         chk($sformatf("v%0d.ir_valid", i), 32'(bus.ir_valid),  32'(vecs[i].e_iv));
         chk($sformatf("v%0d.halted", i),   32'(bus.halted),    32'(vecs[i].e_halt));
         if (vecs[i].e_iv) begin
            chk($sformatf("v%0d.ir_pc", i),  32'(bus.ir_pc),  32'(vecs[i].e_irpc));
            chk($sformatf("v%0d.opcode", i), 32'(bus.opcode), 32'(vecs[i].e_op));
            chk($sformatf("v%0d.ir", i),     32'(bus.ir),     32'(mem[vecs[i].e_irpc]));
         end
         tick();
      end

      // HALT at address 3, stays halted, redirect resumes at 0x10
      mem[3] = word(OP_HALT, 16'h0003);
      drive(1, 0, 1, 0, '0);
      tick();
      drive(0, 0, 1, 0, '0);
      for (int c = 0; c < 4; c++) tick();
      #1;
      chk("halt.halted",   32'(bus.halted),   32'h1);
      chk("halt.ir_valid", 32'(bus.ir_valid), 32'h1);
      chk("halt.opcode",   32'(bus.opcode),   32'(OP_HALT));
      chk("halt.ir_pc",    32'(bus.ir_pc),    32'h3);
      chk("halt.req",      32'(bus.imem_req), 32'h0);
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("halt.idle%0d.req", c),    32'(bus.imem_req), 32'h0);
         chk($sformatf("halt.idle%0d.halted", c), 32'(bus.halted),   32'h1);
      end
      chk("halt.consumed", 32'(bus.ir_valid), 32'h0);
      drive(0, 0, 1, 1, 16'h0010);
      tick();
      drive(0, 0, 1, 0, '0);
      #1;
      chk("resume.halted",   32'(bus.halted),    32'h0);
      chk("resume.req",      32'(bus.imem_req),  32'h1);
      chk("resume.addr",     32'(bus.imem_addr), 32'h10);
      chk("resume.ir_valid", 32'(bus.ir_valid),  32'h0);
      tick();
      chk("resume.ir_pc",  32'(bus.ir_pc),  32'h10);
      chk("resume.opcode", 32'(bus.opcode), 32'(OP_ADD));

      // Reset mid-stream with ir_valid and halted set; reset beats a same-cycle redirect
      drive(1, 0, 1, 0, '0);
      tick();
      drive(0, 0, 1, 0, '0);
      for (int c = 0; c < 4; c++) tick();
      chk("pre_rst.halted",   32'(bus.halted),   32'h1);
      chk("pre_rst.ir_valid", 32'(bus.ir_valid), 32'h1);
      drive(1, 0, 1, 1, 16'h0020);
      #1;
      chk("mid_rst.req", 32'(bus.imem_req), 32'h0);
      tick();
      drive(0, 0, 1, 0, '0);
      #1;
      chk("post_rst.ir_valid", 32'(bus.ir_valid),  32'h0);
      chk("post_rst.halted",   32'(bus.halted),    32'h0);
      chk("post_rst.ir",       32'(bus.ir),        32'h0);
      chk("post_rst.ir_pc",    32'(bus.ir_pc),     32'h0);
      chk("post_rst.addr",     32'(bus.imem_addr), 32'h0);
      chk("post_rst.req",      32'(bus.imem_req),  32'h1);
      tick();
      chk("restart.ir_valid", 32'(bus.ir_valid), 32'h1);
      chk("restart.ir_pc",    32'(bus.ir_pc),    32'h0);
      chk("restart.opcode",   32'(bus.opcode),   32'(OP_ADD));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
